// File: rtl/ffd_univ_reg_if.sv
// Control/data bundle for ffd_univ_reg. The clr signal exists only when
// FFD_UNIV_CLR_EN is defined.
interface ffd_univ_reg_if #(
    parameter int WIDTH = 4
);
    logic             enable;
    logic [2:0]       mode;
    logic [WIDTH-1:0] d;
    logic             sin;
`ifdef FFD_UNIV_CLR_EN
    logic             clr;
`endif
    logic [WIDTH-1:0] q;
    logic             flag;
    logic             zero;

`ifdef FFD_UNIV_CLR_EN
    modport master (output enable, mode, d, sin, clr, input q, flag, zero);
    modport slave  (input enable, mode, d, sin, clr, output q, flag, zero);
`else
    modport master (output enable, mode, d, sin, input q, flag, zero);
    modport slave  (input enable, mode, d, sin, output q, flag, zero);
`endif
endinterface

// File: rtl/ffd_univ_reg.sv
// Multi-mode WIDTH-bit register: hold/load/shift/rotate/count with a registered
// shift-out/carry/borrow flag. Optional synchronous clear with FFD_UNIV_CLR_EN.
module ffd_univ_reg #(
    parameter int               WIDTH       = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic            clk,
    input  logic            rst,
    ffd_univ_reg_if.slave   bus
);
    localparam logic [2:0] M_HOLD = 3'b000, M_LOAD = 3'b001,
                           M_SHL  = 3'b010, M_SHR  = 3'b011,
                           M_ROL  = 3'b100, M_ROR  = 3'b101,
                           M_UP   = 3'b110, M_DN   = 3'b111;

    logic [WIDTH-1:0] q_r, q_nxt;
    logic             flag_r, flag_nxt;
    logic             clr_w;

`ifdef FFD_UNIV_CLR_EN
    assign clr_w = bus.clr;
`else
    assign clr_w = 1'b0;
`endif

    always_comb begin
        q_nxt    = q_r;
        flag_nxt = flag_r;
        if (clr_w) begin
            q_nxt    = RESET_VALUE;
            flag_nxt = 1'b0;
        end else if (bus.enable) begin
            case (bus.mode)
                M_HOLD: ;
                M_LOAD: begin q_nxt = bus.d;                        flag_nxt = 1'b0;        end
                M_SHL:  begin q_nxt = {q_r[WIDTH-2:0], bus.sin};    flag_nxt = q_r[WIDTH-1]; end
                M_SHR:  begin q_nxt = {bus.sin, q_r[WIDTH-1:1]};    flag_nxt = q_r[0];       end
                M_ROL:  begin q_nxt = {q_r[WIDTH-2:0], q_r[WIDTH-1]}; flag_nxt = q_r[WIDTH-1]; end
                M_ROR:  begin q_nxt = {q_r[0], q_r[WIDTH-1:1]};     flag_nxt = q_r[0];       end
                // carry/borrow is the wrap condition of the pre-update value
                M_UP:   begin q_nxt = q_r + WIDTH'(1);              flag_nxt = &q_r;         end
                M_DN:   begin q_nxt = q_r - WIDTH'(1);              flag_nxt = ~|q_r;        end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_r    <= RESET_VALUE;
            flag_r <= 1'b0;
        end else begin
            q_r    <= q_nxt;
            flag_r <= flag_nxt;
        end
    end

    assign bus.q    = q_r;
    assign bus.flag = flag_r;
    assign bus.zero = (q_r == '0);
endmodule
